// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: shares the single L2 port between the L1 I-cache (read-only)
// and the L1 D-cache (read/write). The winning request is latched into
// registered L2 command strobes that stay constant until L2 responds. The
// response is then steered back to the owner. Saturating per-port grant
// counters are kept for performance monitoring.
module l1_l2_arbiter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_mem_read,
  input  logic [15:0]            i_mem_address,
  output logic                   i_mem_resp,
  output logic [127:0]           i_mem_rdata,
  input  logic                   d_mem_read,
  input  logic                   d_mem_write,
  input  logic [15:0]            d_mem_address,
  input  logic [127:0]           d_mem_wdata,
  output logic                   d_mem_resp,
  output logic [127:0]           d_mem_rdata,
  output logic                   l2_mem_read,
  output logic                   l2_mem_write,
  output logic [15:0]            l2_mem_address,
  output logic [127:0]           l2_mem_wdata,
  input  logic                   l2_mem_resp,
  input  logic [127:0]           l2_mem_rdata,
  output logic [COUNT_WIDTH-1:0] i_grant_count,
  output logic [COUNT_WIDTH-1:0] d_grant_count
);

  localparam int DATA_W = 128;
  localparam int ADDR_W = 16;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t state, state_next;
  logic   last_served;
  logic   i_pend, d_pend;
  logic   grant_i, grant_d, serve_done;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (&v) return v;
    else    return v + CNT_ONE;
  endfunction

  // Arbitration and next state: on a tie the port not served last wins.
  always_comb begin
    state_next = state;
    i_pend     = i_mem_read;
    d_pend     = d_mem_read | d_mem_write;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    serve_done = 1'b0;
    case (state)
      IDLE: begin
        if (d_pend && (!i_pend || last_served == PORT_I)) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end else if (i_pend) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_mem_resp) begin
          serve_done = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Responses are gated by state, so L2 responses in IDLE/DONE never leak out.
  always_comb begin
    i_mem_resp  = (state == SERVE_I) && l2_mem_resp;
    d_mem_resp  = (state == SERVE_D) && l2_mem_resp;
    i_mem_rdata = l2_mem_rdata;
    d_mem_rdata = l2_mem_rdata;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // L2 command registers: loaded only on a grant, so requester changes mid-serve are ignored.
  // A D request with both strobes set is issued as a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l2_mem_read    <= 1'b0;
      l2_mem_write   <= 1'b0;
      l2_mem_address <= {ADDR_W{1'b0}};
      l2_mem_wdata   <= {DATA_W{1'b0}};
    end else if (grant_d) begin
      l2_mem_read    <= ~d_mem_write;
      l2_mem_write   <= d_mem_write;
      l2_mem_address <= d_mem_address;
      l2_mem_wdata   <= d_mem_wdata;
    end else if (grant_i) begin
      l2_mem_read    <= 1'b1;
      l2_mem_write   <= 1'b0;
      l2_mem_address <= i_mem_address;
    end else if (serve_done) begin
      l2_mem_read    <= 1'b0;
      l2_mem_write   <= 1'b0;
    end
  end

  // Round-robin history: updated when a transaction completes; resets to I so D wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        last_served <= PORT_I;
    else if (serve_done) last_served <= (state == SERVE_D) ? PORT_D : PORT_I;
  end

  // Per-port grant counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_grant_count <= {COUNT_WIDTH{1'b0}};
      d_grant_count <= {COUNT_WIDTH{1'b0}};
    end else begin
      if (grant_i) i_grant_count <= sat_inc(i_grant_count);
      if (grant_d) d_grant_count <= sat_inc(d_grant_count);
    end
  end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Testbench for l1_l2_arbiter: directed transactions with a response scoreboard.
module tb_l1_l2_arbiter;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_mem_read;
  logic [15:0]   i_mem_address;
  logic          i_mem_resp;
  logic [127:0]  i_mem_rdata;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [15:0]   d_mem_address;
  logic [127:0]  d_mem_wdata;
  logic          d_mem_resp;
  logic [127:0]  d_mem_rdata;
  logic          l2_mem_read;
  logic          l2_mem_write;
  logic [15:0]   l2_mem_address;
  logic [127:0]  l2_mem_wdata;
  logic          l2_mem_resp;
  logic [127:0]  l2_mem_rdata;
  logic [CW-1:0] i_grant_count;
  logic [CW-1:0] d_grant_count;

  l1_l2_arbiter #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
    .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
    .l2_mem_address(l2_mem_address), .l2_mem_wdata(l2_mem_wdata),
    .l2_mem_resp(l2_mem_resp), .l2_mem_rdata(l2_mem_rdata),
    .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         is_d;
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] i_cnt_exp = '0;
  logic [CW-1:0] d_cnt_exp = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 4'd1;
  endfunction

  // Monitor: every response the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (i_mem_resp || d_mem_resp) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {i_mem_resp, d_mem_resp}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_port", {i_mem_resp, d_mem_resp}, e.is_d ? 2'b01 : 2'b10);
        chk("resp_rdata", e.is_d ? d_mem_rdata : i_mem_rdata, e.rdata);
        chk("resp_l2_addr", l2_mem_address, e.addr);
        chk("resp_l2_strobes", {l2_mem_read, l2_mem_write}, {e.rd, e.wr});
        if (e.wr) chk("resp_l2_wdata", l2_mem_wdata, e.wdata);
      end
    end
  end

  // Expect one grant, check the command, answer after lat cycles, then drop the request.
  task automatic serve(input logic is_d, input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [127:0] wdata, input logic [127:0] rdata, input int lat,
                       input logic scramble);
    exp_t e;
    int waited;
    e.is_d = is_d; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    exp_q.push_back(e);
    waited = 0;
    @(negedge clk);
    while (!(l2_mem_read || l2_mem_write) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("grant_latency", waited, 1);
    if (is_d) d_cnt_exp = inc_sat(d_cnt_exp);
    else      i_cnt_exp = inc_sat(i_cnt_exp);
    chk("grant_addr", l2_mem_address, addr);
    chk("grant_strobes", {l2_mem_read, l2_mem_write}, {rd, wr});
    if (wr) chk("grant_wdata", l2_mem_wdata, wdata);
    chk("grant_i_count", i_grant_count, i_cnt_exp);
    chk("grant_d_count", d_grant_count, d_cnt_exp);
    if (scramble) begin
      d_mem_address = 16'hFFFF;
      d_mem_wdata   = {128{1'b1}};
    end
    repeat (lat) @(posedge clk);
    #1 l2_mem_resp = 1'b1; l2_mem_rdata = rdata;
    @(posedge clk);
    #1 l2_mem_resp = 1'b0; l2_mem_rdata = '0;
    if (is_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
    else      i_mem_read = 1'b0;
    @(negedge clk);
    chk("done_strobes_low", {l2_mem_read, l2_mem_write}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
    l2_mem_resp = 1'b0; l2_mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {l2_mem_read, l2_mem_write}, 2'b00);
    chk("rst_addr", l2_mem_address, 16'h0);
    chk("rst_wdata", l2_mem_wdata, 128'h0);
    chk("rst_counts", {i_grant_count, d_grant_count}, 8'h00);
    chk("rst_resps", {i_mem_resp, d_mem_resp}, 2'b00);
    reset_n = 1'b1;

    // Single I read
    @(posedge clk); #1;
    i_mem_read = 1'b1; i_mem_address = 16'h1230;
    serve(1'b0, 1'b1, 1'b0, 16'h1230, '0, {16{8'hA5}}, 4, 1'b0);
    chk("t1_i_count", i_grant_count, 4'd1);

    // Contention from reset: D first, then I, twice
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    i_cnt_exp = '0; d_cnt_exp = '0;
    for (int r = 0; r < 2; r++) begin
      i_mem_read = 1'b1; i_mem_address = 16'h0100;
      d_mem_write = 1'b1; d_mem_address = 16'h0200; d_mem_wdata = {16{8'h55}};
      serve(1'b1, 1'b0, 1'b1, 16'h0200, {16{8'h55}}, {16{8'h11}}, 2, 1'b0);
      serve(1'b0, 1'b1, 1'b0, 16'h0100, '0, {16{8'h22}}, 1, 1'b0);
      chk("i_keeps_wdata", l2_mem_wdata, {16{8'h55}});
    end

    // Withdrawal: D read inputs change mid-serve
    d_mem_read = 1'b1; d_mem_address = 16'h0300;
    serve(1'b1, 1'b1, 1'b0, 16'h0300, '0, {16{8'h33}}, 3, 1'b1);

    // Tie after D served last: I wins
    i_mem_read = 1'b1; i_mem_address = 16'h0400;
    d_mem_read = 1'b1; d_mem_address = 16'h0500;
    serve(1'b0, 1'b1, 1'b0, 16'h0400, '0, {16{8'h44}}, 1, 1'b0);
    serve(1'b1, 1'b1, 1'b0, 16'h0500, '0, {16{8'h66}}, 2, 1'b0);

    // D read+write together is issued as a write
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 16'h0600; d_mem_wdata = {16{8'hC3}};
    serve(1'b1, 1'b0, 1'b1, 16'h0600, {16{8'hC3}}, {16{8'h77}}, 1, 1'b0);

    // Spurious L2 response in IDLE
    @(posedge clk); #1 l2_mem_resp = 1'b1; l2_mem_rdata = {8{16'hDEAD}};
    @(posedge clk); #1 l2_mem_resp = 1'b0; l2_mem_rdata = '0;
    @(negedge clk);
    chk("spurious_strobes", {l2_mem_read, l2_mem_write}, 2'b00);
    chk("spurious_counts", {i_grant_count, d_grant_count}, {i_cnt_exp, d_cnt_exp});

    // Reset in the middle of an I transaction
    i_mem_read = 1'b1; i_mem_address = 16'h0700;
    n = 0;
    while (!l2_mem_read && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_grant", l2_mem_read, 1'b1);
    @(posedge clk); #1 reset_n = 1'b0; l2_mem_resp = 1'b1; l2_mem_rdata = {16{8'h99}};
    #1;
    chk("rst_mid_strobes", {l2_mem_read, l2_mem_write}, 2'b00);
    chk("rst_mid_counts", {i_grant_count, d_grant_count}, 8'h00);
    chk("rst_mid_addr", l2_mem_address, 16'h0);
    chk("rst_mid_resp", i_mem_resp, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1; l2_mem_resp = 1'b0; l2_mem_rdata = '0;
    i_cnt_exp = '0; d_cnt_exp = '0;
    d_mem_write = 1'b1; d_mem_address = 16'h0800; d_mem_wdata = {16{8'h0F}};
    serve(1'b1, 1'b0, 1'b1, 16'h0800, {16{8'h0F}}, {16{8'h88}}, 1, 1'b0);
    serve(1'b0, 1'b1, 1'b0, 16'h0700, '0, {16{8'hAA}}, 1, 1'b0);

    // Saturation of the I counter
    for (int k = 0; k < 20; k++) begin
      i_mem_read = 1'b1; i_mem_address = 16'h1000 + 16'(k);
      serve(1'b0, 1'b1, 1'b0, 16'h1000 + 16'(k), '0, {16{8'(k)}}, 1, 1'b0);
    end
    chk("i_count_saturated", i_grant_count, 4'hF);
    chk("d_count_after_sat", d_grant_count, 4'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
